adc_spi_master: RTL and testbench
=================================

# adc_spi_master

Byte-wide SPI master between the command processor and the ADC configuration port. It accepts one byte per transfer on a ready/valid pair and shifts it out MSB-first on SCLK/MOSI while shifting in MISO. It returns the received byte with a one-cycle strobe. Chip select stays with the command processor: it is asserted around multi-byte sequences and is not driven here.

## Interface
- CLKS_PER_HALF_BIT, 4, clk cycles per SCLK half-period; legal range 2..255.
- SPI_MODE, 0, SPI mode 0..3; bit1 = CPOL, bit0 = CPHA.

- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- tx_byte  in  8  byte to transmit; sampled only on acceptance.
- tx_dv  in  1  transmit request; accepted when tx_dv=1 and tx_ready=1 at a clk edge.
- tx_ready  out  1  high when idle and able to accept a byte.
- rx_byte  out  8  last received byte; held until the next transfer completes.
- rx_dv  out  1  one-cycle strobe; rx_byte is valid in the same cycle.
- sclk  out  1  SPI clock; idles at CPOL.
- mosi  out  1  SPI data out, MSB first.
- miso  in  1  SPI data in, MSB first.

## Operation
- Reset values:
  - tx_ready=1, rx_dv=0, rx_byte=0x00.
  - sclk=CPOL, mosi=0.
  - Internal state: IDLE, edge counter 0, half-bit counter 0.
- States:
  - IDLE: tx_ready=1. On acceptance, latch tx_byte into the shift register, load the edge counter with 16 and go to SHIFT. tx_ready=0 from the next cycle.
  - SHIFT: the half-bit counter counts 0..CLKS_PER_HALF_BIT-1. At terminal count, sclk toggles and the edge counter decrements. When the edge counter reaches 0, go to DONE in the same edge.
  - DONE is not a separate cycle. In the edge that produces the 16th toggle:
    - rx_byte <= assembled byte.
    - rx_dv <= 1 for exactly one cycle.
    - tx_ready <= 1.
    - state <= IDLE.
- Edge roles:
  - Leading edge = odd toggles 1,3,..,15. Trailing edge = even toggles 2,..,16.
  - CPHA=0:
    - mosi <= tx_byte[7] in the acceptance edge.
    - miso is captured in the clk edge that generates each leading toggle.
    - mosi advances to the next bit at trailing toggles 2..14.
    - Toggle 16 leaves mosi unchanged.
  - CPHA=1:
    - mosi is unchanged at acceptance.
    - mosi advances at each leading toggle (bit7 at toggle 1).
    - miso is captured at trailing toggles 2..16.
- Shift-in: rx shift register <= {rx_shift[6:0], miso}. After 8 captures it holds the received byte MSB-first.
- Non-accepted requests: tx_dv while tx_ready=0 is ignored. No queuing, no error flag.
- Back-to-back: tx_dv=1 in the cycle tx_ready returns high is accepted at the next edge. sclk has then idled at CPOL for at least CLKS_PER_HALF_BIT cycles.
- rx_dv is emitted for every completed byte, including bytes whose read data is don't-care. The consumer filters.
- Reset mid-transfer: abort immediately to the reset values. No rx_dv is emitted for the aborted byte.

## Timing
- Acceptance edge = E0. Let H = CLKS_PER_HALF_BIT.
- Toggle k (1..16) occurs at edge E0 + k·H.
- At E0+16·H: rx_dv=1, tx_ready=1, sclk=CPOL.
- Total latency from acceptance to rx_dv is 16·H cycles. Default: 64 cycles.
- SCLK frequency = f_clk/(2·H). Duty cycle is exactly 50%.
- miso is sampled directly, with no synchronizer. Slave output delay must stay below (H-1)·T_clk.
- Outputs are registered; no combinational path from inputs to outputs.
- tx_ready remains 1 in the idle cycle after rx_dv if tx_dv=0.

## Test plan
- Reset, mode 0, H=4: send 0xA5 with miso looped to mosi.
  - 16 sclk toggles, first rise at E0+4.
  - mosi sequence 1,0,1,0,0,1,0,1 at rises.
  - rx_dv at E0+64 with rx_byte=0xA5.
- Mode 0, miso tied to a model that returns 0x3C:
  - rx_byte=0x3C.
  - tx_ready low from E0+1 through E0+63.
  - rx_dv high for exactly one cycle.
- Command-processor sequence, three bytes 0x80,0x01,0x00, back-to-back on tx_ready:
  - Three rx_dv strobes spaced 64+1 cycles apart.
  - sclk idles low for at least 4 cycles between bytes.
  - Last rx_byte equals the model's register value.
- tx_dv pulsed at E0+10 during a transfer with tx_byte=0xFF:
  - Ignored; the transmitted byte is unchanged.
  - Exactly one rx_dv.
- Each SPI_MODE 1..3 with H=2 and byte 0x5A:
  - sclk idles at CPOL.
  - mosi changes only on the specified edges.
  - Loopback rx_byte=0x5A.
- rst asserted at E0+30:
  - sclk=CPOL, mosi=0, tx_ready=1 immediately.
  - No rx_dv.
  - The next transfer of 0xC3 completes normally.

Source files
------------

// File: rtl/adc_spi_master.sv
`default_nettype none
// adc_spi_master: byte-wide SPI master (modes 0..3) with ready/valid transmit
// and a one-cycle receive strobe. Chip select is owned by the command processor.
module adc_spi_master #(
   parameter int CLKS_PER_HALF_BIT = 4,
   parameter int SPI_MODE          = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_byte,
   input  logic       tx_dv,
   output logic       tx_ready,
   output logic [7:0] rx_byte,
   output logic       rx_dv,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   localparam bit CPOL = (SPI_MODE & 2) != 0;
   localparam bit CPHA = (SPI_MODE & 1) != 0;
   localparam int HCW  = $clog2(CLKS_PER_HALF_BIT);
   localparam logic [HCW-1:0] HALF_LAST = HCW'(CLKS_PER_HALF_BIT - 1);

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   state_t         state;
   state_t         state_next;
   logic [HCW-1:0] half_cnt;
   logic [4:0]     edge_cnt;
   logic [7:0]     tx_shift;
   logic [7:0]     rx_shift;
   logic [7:0]     rx_next;
   logic           accept;
   logic           toggle;
   logic           leading;
   logic           last;
   logic           capture;
   logic           advance;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Edge counter runs 16..1; an even count marks a leading (odd-numbered) toggle.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      toggle     = 1'b0;
      leading    = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (tx_dv) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (half_cnt == HALF_LAST) begin
               toggle  = 1'b1;
               leading = ~edge_cnt[0];
               last    = (edge_cnt == 5'd1);
               if (last) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign capture = toggle && (CPHA ? !leading : leading);
   assign advance = toggle && (CPHA ? leading : (!leading && !last));
   assign rx_next = {rx_shift[6:0], miso};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_cnt <= '0;
         edge_cnt <= 5'd0;
         tx_shift <= 8'h00;
         rx_shift <= 8'h00;
         rx_byte  <= 8'h00;
         rx_dv    <= 1'b0;
         tx_ready <= 1'b1;
         sclk     <= CPOL;
         mosi     <= 1'b0;
      end else begin
         rx_dv <= 1'b0;
         if (accept) begin
            tx_shift <= tx_byte;
            edge_cnt <= 5'd16;
            half_cnt <= '0;
            tx_ready <= 1'b0;
            if (!CPHA) mosi <= tx_byte[7];
         end
         if (state == SHIFT) begin
            half_cnt <= toggle ? '0 : half_cnt + HCW'(1);
         end
         if (toggle) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt - 5'd1;
         end
         // CPHA=0 already presented bit 7 at acceptance, so it advances from bit 6.
         if (advance) begin
            mosi     <= CPHA ? tx_shift[7] : tx_shift[6];
            tx_shift <= {tx_shift[6:0], 1'b0};
         end
         if (capture) rx_shift <= rx_next;
         if (last) begin
            rx_byte  <= CPHA ? rx_next : rx_shift;
            rx_dv    <= 1'b1;
            tx_ready <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_master.sv
`default_nettype none
// tb_adc_spi_master: directed bench; instance 0 is mode 0 / H=4, instances 1..3
// are modes 1..3 with H=2.
module tb_adc_spi_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_byte = 8'h00;
   logic [3:0] tx_dv = 4'b0000;
   logic [3:0] tx_ready;
   logic [3:0] rx_dv;
   logic [3:0] sclk;
   logic [3:0] mosi;
   logic [3:0] miso;
   logic [7:0] rx_byte [4];

   logic       sel_loop = 1'b1;
   logic [7:0] resp [4];
   logic [7:0] model_byte;
   logic       model_bit;

   int         cyc = 0;
   int         e0 = 0;
   int         n_vec = 0;
   int         n_err = 0;
   logic       clr = 1'b0;

   int         tog [4];
   int         rxn [4];
   int         bad [4];
   int         rises [4];
   int         first_tog [4];
   int         last_tog [4];
   int         bt_gap [4];
   int         last_rx [4];
   int         rx_gap [4];
   int         last_low [4];
   logic [7:0] mosi_rise [4];
   logic [3:0] psclk = 4'b0000;
   logic [3:0] pmosi = 4'b0000;
   logic [3:0] prdy  = 4'b0000;

   // new sclk level at which a mosi change is legal: trailing for CPHA=0, leading for CPHA=1
   localparam logic [3:0] MOSI_LVL = 4'b0110;
   localparam logic [3:0] CPHA0    = 4'b0101;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         adc_spi_master #(
            .CLKS_PER_HALF_BIT(gi == 0 ? 4 : 2),
            .SPI_MODE         (gi)
         ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .tx_byte (tx_byte),
            .tx_dv   (tx_dv[gi]),
            .tx_ready(tx_ready[gi]),
            .rx_byte (rx_byte[gi]),
            .rx_dv   (rx_dv[gi]),
            .sclk    (sclk[gi]),
            .mosi    (mosi[gi]),
            .miso    (miso[gi])
         );
      end
   endgenerate

   // slave model for instance 0: bit index follows the count of sclk rises seen so far
   always_comb begin
      model_byte = resp[2'((rises[0] / 8) % 4)];
      model_bit  = model_byte[3'(7 - (rises[0] % 8))];
   end
   assign miso = {mosi[3:1], sel_loop ? mosi[0] : model_bit};

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (clr) begin
            tog[i] = 0; rxn[i] = 0; bad[i] = 0; rises[i] = 0;
            first_tog[i] = -1; last_tog[i] = cyc; bt_gap[i] = 1000;
            last_rx[i] = -1; rx_gap[i] = 0; last_low[i] = -1; mosi_rise[i] = 8'h00;
         end else begin
            if (sclk[i] !== psclk[i]) begin
               tog[i]++;
               if (first_tog[i] < 0) first_tog[i] = cyc;
               if (tog[i] > 1 && (tog[i] % 16) == 1 && (cyc - last_tog[i]) < bt_gap[i])
                  bt_gap[i] = cyc - last_tog[i];
               last_tog[i] = cyc;
               if (sclk[i]) begin
                  rises[i]++;
                  mosi_rise[i] = {mosi_rise[i][6:0], mosi[i]};
               end
            end
            if (mosi[i] !== pmosi[i]) begin
               if (!((sclk[i] !== psclk[i] && sclk[i] == MOSI_LVL[i]) ||
                     (CPHA0[i] && prdy[i] && !tx_ready[i])))
                  bad[i]++;
            end
            if (!tx_ready[i]) last_low[i] = cyc;
            if (rx_dv[i]) begin
               rxn[i]++;
               if (last_rx[i] >= 0) rx_gap[i] = cyc - last_rx[i];
               last_rx[i] = cyc;
            end
         end
         psclk[i] = sclk[i];
         pmosi[i] = mosi[i];
         prdy[i]  = tx_ready[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      clr = 1'b1;
      @(negedge clk);
      #1 clr = 1'b0;
   endtask

   task automatic send(input int i, input logic [7:0] b);
      tx_byte  = b;
      tx_dv[i] = 1'b1;
      @(posedge clk);
      #1 tx_dv[i] = 1'b0;
      e0 = cyc;
   endtask

   task automatic wait_rx(input int i);
      int k;
      k = 0;
      while (rx_dv[i] !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      #1;
      check("rx_dv_seen", rx_dv[i], 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00; resp[3] = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check("rst_tx_ready", tx_ready[0], 1'b1);
      check("rst_rx_dv", rx_dv[0], 1'b0);
      check("rst_rx_byte", rx_byte[0], 8'h00);
      check("rst_sclk", sclk[0], 1'b0);
      check("rst_mosi", mosi[0], 1'b0);
      check("rst_sclk_modes", sclk[3:1], 3'b110);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // loopback 0xA5, mode 0
      sel_loop = 1'b1;
      clear_mon();
      send(0, 8'hA5);
      check("t1_ready_low", tx_ready[0], 1'b0);
      wait_rx(0);
      check("t1_latency", cyc - e0, 64);
      check("t1_rx_byte", rx_byte[0], 8'hA5);
      check("t1_ready_back", tx_ready[0], 1'b1);
      check("t1_sclk_idle", sclk[0], 1'b0);
      check("t1_first_rise", first_tog[0] - e0, 4);
      check("t1_toggles", tog[0], 16);
      check("t1_mosi_at_rise", mosi_rise[0], 8'hA5);
      check("t1_mosi_edges", bad[0], 0);
      @(negedge clk);
      #1;
      check("t1_rx_dv_pulse", rx_dv[0], 1'b0);
      check("t1_rx_count", rxn[0], 1);

      // slave model returns 0x3C
      sel_loop = 1'b0;
      resp[0] = 8'h3C;
      clear_mon();
      send(0, 8'h00);
      wait_rx(0);
      check("t2_rx_byte", rx_byte[0], 8'h3C);
      check("t2_ready_last_low", last_low[0] - e0, 63);
      @(negedge clk);
      #1;
      check("t2_rx_count", rxn[0], 1);

      // three-byte sequence, back-to-back on tx_ready
      resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h96;
      clear_mon();
      send(0, 8'h80);
      wait_rx(0);
      send(0, 8'h01);
      wait_rx(0);
      check("t3_gap1", rx_gap[0], 65);
      send(0, 8'h00);
      wait_rx(0);
      check("t3_gap2", rx_gap[0], 65);
      check("t3_rx_count", rxn[0], 3);
      check("t3_idle_gap", bt_gap[0], 5);
      check("t3_toggles", tog[0], 48);
      check("t3_reg_value", rx_byte[0], 8'h96);

      // request during a transfer is ignored
      sel_loop = 1'b1;
      clear_mon();
      send(0, 8'h42);
      repeat (9) @(posedge clk);
      #1;
      tx_byte  = 8'hFF;
      tx_dv[0] = 1'b1;
      @(posedge clk);
      #1 tx_dv[0] = 1'b0;
      wait_rx(0);
      check("t4_latency", cyc - e0, 64);
      check("t4_rx_byte", rx_byte[0], 8'h42);
      check("t4_mosi_at_rise", mosi_rise[0], 8'h42);
      check("t4_toggles", tog[0], 16);
      repeat (5) @(negedge clk);
      #1;
      check("t4_rx_count", rxn[0], 1);
      check("t4_still_ready", tx_ready[0], 1'b1);
      check("t4_sclk_idle", sclk[0], 1'b0);

      // modes 1..3, H=2, loopback 0x5A
      begin
         logic [3:0] cpol_exp;
         cpol_exp = 4'b1100;
         for (int i = 1; i < 4; i++) begin
            check($sformatf("t5_m%0d_idle_before", i), sclk[i], cpol_exp[i]);
            clear_mon();
            send(i, 8'h5A);
            wait_rx(i);
            check($sformatf("t5_m%0d_latency", i), cyc - e0, 32);
            check($sformatf("t5_m%0d_rx_byte", i), rx_byte[i], 8'h5A);
            check($sformatf("t5_m%0d_mosi_edges", i), bad[i], 0);
            check($sformatf("t5_m%0d_toggles", i), tog[i], 16);
            check($sformatf("t5_m%0d_idle_after", i), sclk[i], cpol_exp[i]);
         end
      end

      // reset mid-transfer
      sel_loop = 1'b1;
      clear_mon();
      send(0, 8'h3C);
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t6_sclk", sclk[0], 1'b0);
      check("t6_mosi", mosi[0], 1'b0);
      check("t6_tx_ready", tx_ready[0], 1'b1);
      check("t6_rx_dv", rx_dv[0], 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      #1;
      check("t6_no_rx_dv", rxn[0], 0);
      clear_mon();
      send(0, 8'hC3);
      wait_rx(0);
      check("t6_latency", cyc - e0, 64);
      check("t6_rx_byte", rx_byte[0], 8'hC3);
      check("t6_mosi_at_rise", mosi_rise[0], 8'hC3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
